// File: rtl/pellet_field.sv
// pellet_field: alive/eaten bookkeeping for every pellet in the maze.
// Once per frame it walks the pellet-position ROM, tests each pellet against
// the latched Pacman position, clears eaten pellets and accumulates score.
module pellet_field #(
    parameter int unsigned             NUM_PELLETS = 64,
    parameter int unsigned             IDX_W       = $clog2(NUM_PELLETS),
    parameter int unsigned             COORD_W     = 10,
    parameter int unsigned             HIT_RADIUS  = 6,
    parameter logic [NUM_PELLETS-1:0]  POWER_MASK  = '0,
    parameter int unsigned             PELLET_PTS  = 10,
    parameter int unsigned             POWER_PTS   = 50,
    parameter int unsigned             SCORE_W     = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic               refill,
    input  logic [COORD_W-1:0] PacmanX,
    input  logic [COORD_W-1:0] PacmanY,
    output logic [IDX_W-1:0]   rom_addr,
    input  logic [COORD_W-1:0] rom_x,
    input  logic [COORD_W-1:0] rom_y,
    input  logic [IDX_W-1:0]   query_idx,
    output logic               query_alive,
    output logic               eat_pulse,
    output logic               eat_power,
    output logic [IDX_W-1:0]   eat_idx,
    output logic [SCORE_W-1:0] score,
    output logic [IDX_W:0]     pellets_left,
    output logic               all_cleared,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_PELLETS - 1);
    localparam logic [IDX_W:0]     FULL_COUNT = (IDX_W + 1)'(NUM_PELLETS);
    // Score sum is formed wide so the saturation test cannot itself overflow.
    localparam int unsigned        SUM_W      = SCORE_W + 32;
    localparam logic [SUM_W-1:0]   SCORE_MAX  = SUM_W'({SCORE_W{1'b1}});

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         rom_addr_q, rom_addr_d;
    logic [COORD_W-1:0]       px_q, px_d, py_q, py_d;
    logic                     cmp_valid_q, cmp_valid_d;
    logic [IDX_W-1:0]         cmp_idx_q, cmp_idx_d;
    logic [NUM_PELLETS-1:0]   alive_q, alive_d;
    logic [IDX_W:0]           left_q, left_d;
    logic [SCORE_W-1:0]       score_q, score_d;
    logic                     busy_q, busy_d;
    logic                     eat_pulse_q, eat_pulse_d;
    logic                     eat_power_q, eat_power_d;
    logic [IDX_W-1:0]         eat_idx_q, eat_idx_d;
    logic                     query_alive_q, query_alive_d;
    logic                     all_cleared_q, all_cleared_d;

    logic [COORD_W-1:0]       dx, dy;
    logic                     hit;
    logic [SUM_W-1:0]         score_sum;

    // Proximity test for the pellet whose ROM data is on rom_x/rom_y this cycle.
    always_comb begin
        // Subtract smaller from larger so the difference never wraps.
        dx = (px_q >= rom_x) ? (px_q - rom_x) : (rom_x - px_q);
        dy = (py_q >= rom_y) ? (py_q - rom_y) : (rom_y - py_q);
        hit = cmp_valid_q && alive_q[cmp_idx_q] &&
              (32'(dx) <= HIT_RADIUS) && (32'(dy) <= HIT_RADIUS);
        score_sum = SUM_W'(score_q) +
                    SUM_W'(POWER_MASK[cmp_idx_q] ? POWER_PTS : PELLET_PTS);
    end

    // Next-state logic: scan FSM, pellet clearing, scoring and renderer read.
    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        px_d          = px_q;
        py_d          = py_q;
        cmp_valid_d   = cmp_valid_q;
        cmp_idx_d     = cmp_idx_q;
        alive_d       = alive_q;
        left_d        = left_q;
        score_d       = score_q;
        busy_d        = busy_q;
        eat_pulse_d   = 1'b0;
        eat_power_d   = 1'b0;
        eat_idx_d     = eat_idx_q;
        query_alive_d = alive_q[query_idx];

        if (refill) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            rom_addr_d  = '0;
            cmp_valid_d = 1'b0;
            alive_d     = '1;
            left_d      = FULL_COUNT;
        end else begin
            if (hit) begin
                alive_d[cmp_idx_q] = 1'b0;
                left_d      = left_q - 1'b1;
                score_d     = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
                eat_pulse_d = 1'b1;
                eat_idx_d   = cmp_idx_q;
                eat_power_d = POWER_MASK[cmp_idx_q];
            end

            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        px_d       = PacmanX;
                        py_d       = PacmanY;
                        rom_addr_d = '0;
                        busy_d     = 1'b1;
                        state_d    = SCAN;
                    end
                end
                SCAN: begin
                    // ROM answers one cycle later, so the compare trails the address.
                    cmp_valid_d = 1'b1;
                    cmp_idx_d   = rom_addr_q;
                    if (rom_addr_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    cmp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
                default: begin
                    cmp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            endcase
        end

        all_cleared_d = (left_d == '0);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            rom_addr_q    <= '0;
            px_q          <= '0;
            py_q          <= '0;
            cmp_valid_q   <= 1'b0;
            cmp_idx_q     <= '0;
            alive_q       <= '1;
            left_q        <= FULL_COUNT;
            score_q       <= '0;
            busy_q        <= 1'b0;
            eat_pulse_q   <= 1'b0;
            eat_power_q   <= 1'b0;
            eat_idx_q     <= '0;
            query_alive_q <= 1'b0;
            all_cleared_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            px_q          <= px_d;
            py_q          <= py_d;
            cmp_valid_q   <= cmp_valid_d;
            cmp_idx_q     <= cmp_idx_d;
            alive_q       <= alive_d;
            left_q        <= left_d;
            score_q       <= score_d;
            busy_q        <= busy_d;
            eat_pulse_q   <= eat_pulse_d;
            eat_power_q   <= eat_power_d;
            eat_idx_q     <= eat_idx_d;
            query_alive_q <= query_alive_d;
            all_cleared_q <= all_cleared_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign query_alive  = query_alive_q;
    assign eat_pulse    = eat_pulse_q;
    assign eat_power    = eat_power_q;
    assign eat_idx      = eat_idx_q;
    assign score        = score_q;
    assign pellets_left = left_q;
    assign all_cleared  = all_cleared_q;
    assign busy         = busy_q;

endmodule
